// File: rtl/sdhc_cmd_line_if.sv
// Signal bundle between the SD command engine, its controller-side request/response
// ports and the CMD pad. The engine connects through the slave modport.
interface sdhc_cmd_line_if;
    // Request: cmd_valid_i/cmd_ready_o, transfer on the cycle both are high.
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [5:0]  cmd_index_i;
    logic [31:0] cmd_arg_i;
    logic        cmd_resp_i;

    // Pad side
    logic        cmd_o;
    logic        cmd_oe_o;
    logic        cmd_i;

    // Response: rsp_valid_o/rsp_ready_i, transfer on the cycle both are high.
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [5:0]  rsp_index_o;
    logic [31:0] rsp_arg_o;
    logic        rsp_timeout_o;
    logic        rsp_crc_err_o;
    logic        rsp_frame_err_o;

    modport master (
        output cmd_valid_i, cmd_index_i, cmd_arg_i, cmd_resp_i, cmd_i, rsp_ready_i,
        input  cmd_ready_o, cmd_o, cmd_oe_o, rsp_valid_o, rsp_index_o, rsp_arg_o,
               rsp_timeout_o, rsp_crc_err_o, rsp_frame_err_o
    );

    modport slave (
        input  cmd_valid_i, cmd_index_i, cmd_arg_i, cmd_resp_i, cmd_i, rsp_ready_i,
        output cmd_ready_o, cmd_o, cmd_oe_o, rsp_valid_o, rsp_index_o, rsp_arg_o,
               rsp_timeout_o, rsp_crc_err_o, rsp_frame_err_o
    );
endinterface

// File: rtl/sdhc_cmd_line.sv
// SD CMD-line engine: serialises one 48-bit command frame with CRC7, then captures
// and checks the 48-bit card response, all paced by the SD bit strobe tick_i.
module sdhc_cmd_line #(
    parameter int RespTimeoutTicks = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tick_i,
    sdhc_cmd_line_if.slave       bus,
    output logic [2:0]           state_o
);

    localparam int WaitW = $clog2(RespTimeoutTicks + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(RespTimeoutTicks - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TX   = 3'd1,
        S_NCR  = 3'd2,
        S_RX   = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [47:0]        shift_q, shift_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic               resp_q, resp_d;
    logic [6:0]         crc_q, crc_d;
    logic               cmd_q, cmd_d;
    logic               oe_q, oe_d;
    logic               valid_q, valid_d;
    logic [5:0]         index_q, index_d;
    logic [31:0]        arg_q, arg_d;
    logic               to_q, to_d;
    logic               crc_err_q, crc_err_d;
    logic               frame_err_q, frame_err_d;

    logic [39:0]        header;
    logic [47:0]        rx_word;

    // x^7 + x^3 + 1, one bit per call, MSB-first
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    function automatic logic [6:0] crc7_block(input logic [39:0] d);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            c = crc7_step(c, d[i]);
        end
        return c;
    endfunction

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        resp_d      = resp_q;
        crc_d       = crc_q;
        cmd_d       = cmd_q;
        oe_d        = oe_q;
        valid_d     = valid_q;
        index_d     = index_q;
        arg_d       = arg_q;
        to_d        = to_q;
        crc_err_d   = crc_err_q;
        frame_err_d = frame_err_q;
        header      = {2'b01, bus.cmd_index_i, bus.cmd_arg_i};
        rx_word     = {shift_q[46:0], bus.cmd_i};

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    shift_d     = {header, crc7_block(header), 1'b1};
                    cmd_d       = 1'b0;
                    oe_d        = 1'b1;
                    cnt_d       = 6'd0;
                    wait_d      = '0;
                    crc_d       = 7'd0;
                    resp_d      = bus.cmd_resp_i;
                    index_d     = 6'd0;
                    arg_d       = 32'd0;
                    to_d        = 1'b0;
                    crc_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                    state_d     = S_TX;
                end
            end

            S_TX: begin
                if (tick_i) begin
                    if (cnt_q == 6'd47) begin
                        cmd_d   = 1'b1;
                        oe_d    = 1'b0;
                        cnt_d   = 6'd0;
                        if (resp_q) begin
                            state_d = S_NCR;
                        end else begin
                            valid_d = 1'b1;
                            state_d = S_DONE;
                        end
                    end else begin
                        shift_d = {shift_q[46:0], 1'b0};
                        cmd_d   = shift_q[46];
                        cnt_d   = cnt_q + 6'd1;
                    end
                end
            end

            S_NCR: begin
                if (tick_i) begin
                    if (!bus.cmd_i) begin
                        // The start bit is frame bit 47 and already part of the CRC span.
                        shift_d = 48'd0;
                        crc_d   = crc7_step(crc_q, 1'b0);
                        cnt_d   = 6'd1;
                        state_d = S_RX;
                    end else if (wait_q == WaitLast) begin
                        to_d    = 1'b1;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        wait_d = wait_q + WaitW'(1);
                    end
                end
            end

            S_RX: begin
                if (tick_i) begin
                    shift_d = rx_word;
                    if (cnt_q < 6'd40) begin
                        crc_d = crc7_step(crc_q, bus.cmd_i);
                    end
                    if (cnt_q == 6'd47) begin
                        index_d     = rx_word[45:40];
                        arg_d       = rx_word[39:8];
                        crc_err_d   = (rx_word[7:1] != crc_q);
                        frame_err_d = rx_word[46] | ~rx_word[0];
                        valid_d     = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end

            S_DONE: begin
                if (bus.rsp_ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            shift_q     <= 48'd0;
            cnt_q       <= 6'd0;
            wait_q      <= '0;
            resp_q      <= 1'b0;
            crc_q       <= 7'd0;
            cmd_q       <= 1'b1;
            oe_q        <= 1'b0;
            valid_q     <= 1'b0;
            index_q     <= 6'd0;
            arg_q       <= 32'd0;
            to_q        <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            resp_q      <= resp_d;
            crc_q       <= crc_d;
            cmd_q       <= cmd_d;
            oe_q        <= oe_d;
            valid_q     <= valid_d;
            index_q     <= index_d;
            arg_q       <= arg_d;
            to_q        <= to_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.cmd_ready_o     = (state_q == S_IDLE);
    assign bus.cmd_o           = cmd_q;
    assign bus.cmd_oe_o        = oe_q;
    assign bus.rsp_valid_o     = valid_q;
    assign bus.rsp_index_o     = index_q;
    assign bus.rsp_arg_o       = arg_q;
    assign bus.rsp_timeout_o   = to_q;
    assign bus.rsp_crc_err_o   = crc_err_q;
    assign bus.rsp_frame_err_o = frame_err_q;
    assign state_o             = state_q;

endmodule

// File: tb/tb_sdhc_cmd_line.sv
// Directed bench for sdhc_cmd_line: captures transmitted frames, plays a card model
// on cmd_i and checks responses against an expected-value queue.
module tb_sdhc_cmd_line;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_i;
    logic [2:0] dbg_state;

    sdhc_cmd_line_if bus();

    sdhc_cmd_line #(.RespTimeoutTicks(64)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .tick_i  (tick_i),
        .bus     (bus.slave),
        .state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [47:0] exp_tx_q[$];
    logic [40:0] exp_rsp_q[$];

    logic [47:0] tx_cap;
    int          tx_bits;
    bit          last_tick;

    int          card_mode;      // 0 off, 1 armed, 2 idle ticks, 3 sending
    bit          card_oe_seen;
    logic [47:0] card_frame;
    int          card_delay;
    int          card_cnt;
    int          card_bi;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Polynomial long division by x^7+x^3+1 (0x89)
    function automatic logic [6:0] tb_crc7(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'd0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] mk48(input logic tbit, input logic [5:0] idx,
                                         input logic [31:0] arg, input logic ebit);
        logic [39:0] h;
        h = {1'b0, tbit, idx, arg};
        return {h, tb_crc7(h), ebit};
    endfunction

    function automatic logic [40:0] rv(input logic to, input logic ce, input logic fe,
                                       input logic [5:0] idx, input logic [31:0] arg);
        return {to, ce, fe, idx, arg};
    endfunction

    function automatic logic [40:0] obs_rsp();
        return {bus.rsp_timeout_o, bus.rsp_crc_err_o, bus.rsp_frame_err_o,
                bus.rsp_index_o, bus.rsp_arg_o};
    endfunction

    task automatic arm_card(input logic [47:0] frame, input int delay);
        card_frame   = frame;
        card_delay   = delay;
        card_oe_seen = 1'b0;
        card_mode    = 1;
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_oe"},    bus.cmd_oe_o, 1'b0);
        check({tag, "_cmd"},   bus.cmd_o, 1'b1);
        check({tag, "_valid"}, bus.rsp_valid_o, 1'b0);
        check({tag, "_ready"}, bus.cmd_ready_o, 1'b1);
        check({tag, "_data"},  obs_rsp(), 41'd0);
    endtask

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic resp);
        @(posedge clk); #1;
        bus.cmd_index_i = idx;
        bus.cmd_arg_i   = arg;
        bus.cmd_resp_i  = resp;
        bus.cmd_valid_i = 1'b1;
        tx_bits = 0;
        tx_cap  = '0;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_index_i = 6'($urandom);
        bus.cmd_arg_i   = $urandom;
        bus.cmd_resp_i  = ~resp;
        @(negedge clk);
        check("start_bit", {bus.cmd_oe_o, bus.cmd_o}, 2'b10);
    endtask

    task automatic wait_rsp(output int ncr_ticks, output bit ok);
        bit oe_seen;
        bit fell;
        oe_seen = 1'b0;
        fell = 1'b0;
        ncr_ticks = 0;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bus.rsp_valid_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (bus.cmd_oe_o === 1'b1) oe_seen = 1'b1;
            else if (oe_seen) fell = 1'b1;
            if (fell && tick_i) ncr_ticks++;
        end
    endtask

    task automatic handshake(input string tag);
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        check({tag, "_handshake"}, {bus.rsp_valid_o, bus.cmd_ready_o}, 2'b01);
    endtask

    task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input logic resp, input logic [47:0] exp_frame,
                           input logic [40:0] exp_rsp, input int exp_ncr, input bit do_hs);
        int          ncr;
        bit          ok;
        logic [47:0] ef;
        logic [40:0] er;
        exp_tx_q.push_back(exp_frame);
        exp_rsp_q.push_back(exp_rsp);
        issue(idx, arg, resp);
        wait_rsp(ncr, ok);
        ef = exp_tx_q.pop_front();
        er = exp_rsp_q.pop_front();
        check({tag, "_rsp_valid"}, ok, 1'b1);
        if (ok) begin
            check({tag, "_tx_bits"}, tx_bits, 48);
            check({tag, "_tx_frame"}, tx_cap, ef);
            check({tag, "_rsp"}, obs_rsp(), er);
            if (exp_ncr >= 0) check({tag, "_ncr_ticks"}, ncr, exp_ncr);
            if (do_hs) handshake(tag);
        end
    endtask

    // ---------------- tick strobe: one cycle in four ----------------
    initial begin
        int div;
        div = 0;
        tick_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            tick_i = (div == 3);
            div = (div + 1) % 4;
        end
    end

    // ---------------- frame capture at ticks while driven ----------------
    initial begin
        tx_bits = 0;
        tx_cap = '0;
        last_tick = 1'b0;
        forever begin
            @(negedge clk);
            last_tick = tick_i;
            if (tick_i && bus.cmd_oe_o === 1'b1) begin
                tx_cap = {tx_cap[46:0], bus.cmd_o};
                tx_bits++;
            end
        end
    end

    // ---------------- card model on cmd_i ----------------
    initial begin
        bus.cmd_i = 1'b1;
        card_mode = 0;
        forever begin
            @(posedge clk); #1;
            case (card_mode)
                1: begin
                    if (bus.cmd_oe_o === 1'b1) card_oe_seen = 1'b1;
                    else if (card_oe_seen) begin
                        card_mode = 2;
                        card_cnt = 0;
                    end
                end
                2: if (last_tick) begin
                    card_cnt++;
                    if (card_cnt == card_delay) begin
                        card_bi = 47;
                        bus.cmd_i = card_frame[47];
                        card_mode = 3;
                    end
                end
                3: if (last_tick) begin
                    if (card_bi == 0) begin
                        bus.cmd_i = 1'b1;
                        card_mode = 0;
                    end else begin
                        card_bi--;
                        bus.cmd_i = card_frame[card_bi];
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [47:0] f;
        logic [40:0] er;
        logic [5:0]  ri;
        logic [31:0] ra;
        logic [31:0] ca;
        bit          reached;

        rst = 1'b1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_index_i = 6'd0;
        bus.cmd_arg_i   = 32'd0;
        bus.cmd_resp_i  = 1'b0;
        bus.rsp_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_check("reset");
        check("reset_state", dbg_state, 3'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // CMD0, no response
        run_cmd("cmd0", 6'd0, 32'h0, 1'b0, 48'h400000000095, 41'd0, -1, 1'b1);

        // CMD8 with a clean R7 after 5 idle ticks
        arm_card(48'h08000001AA13, 5);
        run_cmd("cmd8", 6'd8, 32'h000001AA, 1'b1, 48'h48000001AA87,
                rv(1'b0, 1'b0, 1'b0, 6'h08, 32'h000001AA), 53, 1'b1);

        // CMD17, response with argument bit 5 flipped
        f = mk48(1'b0, 6'd17, 32'h0, 1'b1);
        f[13] = ~f[13];
        arm_card(f, 2);
        run_cmd("cmd17_crc", 6'd17, 32'h0, 1'b1, 48'h510000000055,
                rv(1'b0, 1'b1, 1'b0, 6'd17, 32'h20), -1, 1'b1);

        // No start bit ever arrives
        run_cmd("timeout", 6'd13, 32'h12340000, 1'b1, mk48(1'b1, 6'd13, 32'h12340000, 1'b1),
                rv(1'b1, 1'b0, 1'b0, 6'd0, 32'd0), 64, 1'b1);

        // Random commands with clean responses
        for (int n = 0; n < 3; n++) begin
            ri = 6'($urandom_range(1, 63));
            ra = $urandom;
            ca = $urandom;
            arm_card(mk48(1'b0, ri, ra, 1'b1), $urandom_range(1, 10));
            run_cmd("rand", ri, ca, 1'b1, mk48(1'b1, ri, ca, 1'b1),
                    rv(1'b0, 1'b0, 1'b0, ri, ra), -1, 1'b1);
        end

        // Transmission bit set to 1
        arm_card(mk48(1'b1, 6'd3, 32'hCAFE0000, 1'b1), 4);
        run_cmd("tbit_err", 6'd3, 32'h0, 1'b1, mk48(1'b1, 6'd3, 32'h0, 1'b1),
                rv(1'b0, 1'b0, 1'b1, 6'd3, 32'hCAFE0000), -1, 1'b1);

        // End bit 0, then hold the response unacknowledged
        er = rv(1'b0, 1'b0, 1'b1, 6'd55, 32'h00000120);
        arm_card(mk48(1'b0, 6'd55, 32'h00000120, 1'b0), 3);
        run_cmd("ebit_err", 6'd55, 32'h0, 1'b1, mk48(1'b1, 6'd55, 32'h0, 1'b1), er, -1, 1'b0);
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_index_i = 6'd0;
        bus.cmd_arg_i   = 32'h0;
        bus.cmd_resp_i  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold", {bus.rsp_valid_o, bus.cmd_ready_o, bus.cmd_oe_o, obs_rsp()},
                  {3'b100, er});
        end
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        handshake("hold");

        // Reset during TX, after bit 20
        issue(6'd2, 32'h0, 1'b0);
        reached = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (tx_bits >= 20) begin
                reached = 1'b1;
                break;
            end
        end
        check("mid_tx_reached", {reached, 32'(tx_bits)}, {1'b1, 32'd20});
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_check("rst_tx");
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset during RX
        arm_card(mk48(1'b0, 6'd8, 32'h1AA, 1'b1), 3);
        issue(6'd8, 32'h1AA, 1'b1);
        reached = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (card_mode == 3 && card_bi < 30) begin
                reached = 1'b1;
                break;
            end
        end
        check("mid_rx_reached", reached, 1'b1);
        rst = 1'b1;
        card_mode = 0;
        bus.cmd_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_check("rst_rx");
        @(posedge clk); #1;
        rst = 1'b0;

        run_cmd("cmd0_after_rst", 6'd0, 32'h0, 1'b0, 48'h400000000095, 41'd0, -1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdhc_cmd_line.md
# sdhc_cmd_line

Command-line engine for the SD host path. Accepts one SD command (index, argument, response type) from the controller-side request port and serialises it as a 48-bit SD command frame with CRC7 onto the pad-side CMD line. It then captures the 48-bit card response with start-bit timeout, CRC7 and framing checks, and returns it on a response port. It sits between `cdns_sdhc` command sequencing and the CMD pad, and runs on the controller clock, paced by an SD bit strobe.

## Interface
- `RespTimeoutTicks`, default 64: number of bit ticks to wait for a response start bit (Ncr) before flagging a timeout; minimum 2.
- `clk_i` in 1: controller clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `tick_i` in 1: SD bit strobe, one cycle wide; each high cycle advances the line by one bit.
- `cmd_valid_i` in 1: command request valid.
- `cmd_ready_o` out 1: engine idle and able to accept a command.
- `cmd_index_i` in 6: command index.
- `cmd_arg_i` in 32: command argument.
- `cmd_resp_i` in 1: 1 = expect a 48-bit response; 0 = no response.
- `cmd_o` out 1: CMD pad output value.
- `cmd_oe_o` out 1: CMD pad output enable.
- `cmd_i` in 1: CMD pad input, already synchronised.
- `rsp_valid_o` out 1: response or completion available.
- `rsp_ready_i` in 1: consumer accepts the response.
- `rsp_index_o` out 6: received response index bits [45:40].
- `rsp_arg_o` out 32: received response bits [39:8].
- `rsp_timeout_o` out 1: no start bit within `RespTimeoutTicks`.
- `rsp_crc_err_o` out 1: received CRC7 ≠ CRC7 computed over response bits [47:8].
- `rsp_frame_err_o` out 1: response transmission bit ≠ 0 or end bit ≠ 1.

## Operation
States:
- IDLE: `cmd_ready_o`=1. Acceptance is `cmd_valid_i & cmd_ready_o`. On acceptance, load the shift register with {0, 1, index, arg, CRC7, 1}, go to TX, clear the counters.
- TX: drives `cmd_oe_o`=1 and `cmd_o`=current bit, MSB first. Each tick shifts one bit.
  - After the tick that completes bit 48, `cmd_oe_o`=0 and `cmd_o`=1.
  - Next state is NCR if `cmd_resp_i` was latched 1; otherwise DONE with all flags 0 and data 0.
- NCR: on each tick, sample `cmd_i`.
  - Sample 0 → RX. Start bit is counted as bit 47.
  - Sample 1 → increment the wait counter. Counter reaching `RespTimeoutTicks` → DONE with `rsp_timeout_o`=1 and data 0.
- RX: on each tick, shift in `cmd_i` until 48 bits are held, then go to DONE. At that point:
  - Set `rsp_crc_err_o` from a CRC7 computed incrementally over bits 47..8.
  - Set `rsp_frame_err_o` from bit 46 and bit 0.
- DONE: `rsp_valid_o`=1 and outputs stable until `rsp_ready_i`; the handshake cycle returns to IDLE.

CRC rules:
- CRC7 polynomial x^7+x^3+1, register initialised to 0.
- CRC is computed over the first 40 frame bits. It is used for both TX and RX.

`cmd_i` is ignored outside NCR/RX. `tick_i` is ignored in IDLE and DONE. `cmd_valid_i` is ignored while `cmd_ready_o`=0; the latched command is held, so input changes have no effect.

## Timing
- Reset values, at the first edge with `rst_i`=1:
  - State = IDLE, `cmd_ready_o`=1, `cmd_o`=1, `cmd_oe_o`=0.
  - `rsp_valid_o`=0; all `rsp_*` data and flags = 0.
- All outputs are registered except `cmd_ready_o`, which decodes the registered state.
- Start bit appears on `cmd_o` with `cmd_oe_o`=1 in the cycle after acceptance. Each tick-high cycle changes `cmd_o` at the following edge.
- TX lasts exactly 48 ticks. `cmd_oe_o` falls at the edge after the 48th tick.
- NCR samples `cmd_i` at edges where `tick_i`=1. It begins with the first tick after `cmd_oe_o` falls.
- `rsp_valid_o` rises at the edge after the final RX tick, the timeout tick, or the final TX tick (no-response case).
- `rsp_valid_o` with `rsp_ready_i`=1 in the same cycle: it falls at the next edge, and `cmd_ready_o`=1 from that edge.
- `rst_i` asserted in any state aborts at the next edge: CMD line released (`cmd_oe_o`=0, `cmd_o`=1), any pending response dropped, all outputs at reset values.
- Back-to-back commands:
  - The earliest new acceptance is the cycle after the DONE handshake.
  - Throughput is bounded by ticks, not `clk_i`.

## Test plan
- CMD0, arg 0x00000000, no response, `tick_i` every 4 cycles → `cmd_o` frame 0x400000000095 over 48 ticks. `rsp_valid_o` then asserts with all flags 0.
- CMD8, arg 0x000001AA, response expected; card model returns 0x08000001AA13 after 5 idle ticks → frame sent 0x48000001AA87. Response: `rsp_index_o`=0x08, `rsp_arg_o`=0x000001AA, CRC/frame/timeout flags 0.
- CMD17, arg 0 (frame 0x510000000055); response with one flipped argument bit → `rsp_crc_err_o`=1, `rsp_frame_err_o`=0.
- Response expected, `cmd_i` held 1 → `rsp_timeout_o`=1 exactly at tick 64 after `cmd_oe_o` falls. `rsp_arg_o`=0.
- Response with end bit 0 or transmission bit 1 → `rsp_frame_err_o`=1. Also hold `rsp_ready_i`=0 for 10 cycles → `rsp_valid_o` and data stay stable; `cmd_valid_i` stays unaccepted until the handshake.
- `rst_i` pulsed mid-TX at bit 20 and again mid-RX → next edge `cmd_oe_o`=0, `cmd_o`=1, `rsp_valid_o`=0, `cmd_ready_o`=1. A subsequent CMD0 transmits correctly.
